// File: rtl/wb_spi_master.sv
// Wishbone classic slave SPI master: mode 0, MSB-first, 8-bit frames, one software chip select.
// Registers: DATA (0), STATUS (1), DIV (2), CS (3), decoded from wb_adr_i[3:2].
module wb_spi_master #(
    parameter int unsigned              DIV_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0]     DIV_RESET = DIV_WIDTH'(3)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        spi_cs_n
);

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    localparam logic [1:0] AdrData   = 2'd0;
    localparam logic [1:0] AdrStatus = 2'd1;
    localparam logic [1:0] AdrDiv    = 2'd2;
    localparam logic [1:0] AdrCs     = 2'd3;

    state_e               state_q, state_d;
    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
    logic                 cs_q, cs_d;
    logic                 busy_q, busy_d;
    logic                 rxv_q, rxv_d;
    logic                 ovr_q, ovr_d;
    logic [7:0]           rx_data_q, rx_data_d;
    logic [7:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;

    logic        req, wr, rd;
    logic [1:0]  adr;
    logic [31:0] rdata;
    logic [31:0] div_mask;
    logic        start;

    assign req   = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr    = req & wb_we_i;
    assign rd    = req & ~wb_we_i;
    assign adr   = wb_adr_i[3:2];
    assign start = wr & (adr == AdrData) & wb_sel_i[0] & (state_q == StIdle);

    assign div_mask = {16'h0000, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    always_comb begin
        rdata = 32'h0;
        unique case (adr)
            AdrData:   rdata = {24'h0, rx_data_q};
            AdrStatus: rdata = {29'h0, ovr_q, rxv_q, busy_q};
            AdrDiv:    rdata = 32'(div_q);
            AdrCs:     rdata = {31'h0, cs_q};
            default:   rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ack_d      = req;
        dat_d      = rd ? rdata : 32'h0;
        div_d      = div_q;
        div_cnt_d  = div_cnt_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        rxv_d      = rxv_q;
        ovr_d      = ovr_q;
        rx_data_d  = rx_data_q;
        rx_shift_d = rx_shift_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;

        if (wr) begin
            unique case (adr)
                AdrData: begin
                    if (wb_sel_i[0] && state_q != StIdle) ovr_d = 1'b1;
                end
                AdrStatus: begin
                    if (wb_sel_i[0] && wb_dat_i[2]) ovr_d = 1'b0;
                end
                AdrDiv: begin
                    div_d = (div_q & ~div_mask[DIV_WIDTH-1:0]) |
                            (wb_dat_i[DIV_WIDTH-1:0] & div_mask[DIV_WIDTH-1:0]);
                end
                AdrCs: begin
                    if (wb_sel_i[0]) cs_d = wb_dat_i[0];
                end
                default: ;
            endcase
        end

        if (rd && adr == AdrData) rxv_d = 1'b0;

        // Completion below overrides the read-clear of rx_valid on a coincident cycle.
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d    = 1'b1;
                    shreg_d   = wb_dat_i[7:0];
                    mosi_d    = wb_dat_i[7];
                    bit_cnt_d = 3'd7;
                    div_cnt_d = div_q;
                    state_d   = StLo;
                end
            end
            StLo: begin
                if (div_cnt_q == '0) begin
                    sclk_d     = 1'b1;
                    rx_shift_d = {rx_shift_q[6:0], spi_miso};
                    div_cnt_d  = div_q;
                    state_d    = StHi;
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            StHi: begin
                if (div_cnt_q == '0) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = div_q;
                    if (bit_cnt_q == 3'd0) begin
                        rx_data_d = rx_shift_q;
                        rxv_d     = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        shreg_d   = {shreg_q[6:0], 1'b0};
                        mosi_d    = shreg_q[6];
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        state_d   = StLo;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            div_q      <= DIV_RESET;
            div_cnt_q  <= '0;
            cs_q       <= 1'b0;
            busy_q     <= 1'b0;
            rxv_q      <= 1'b0;
            ovr_q      <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_shift_q <= 8'h00;
            shreg_q    <= 8'h00;
            bit_cnt_q  <= 3'd0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            div_q      <= div_d;
            div_cnt_q  <= div_cnt_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            rxv_q      <= rxv_d;
            ovr_q      <= ovr_d;
            rx_data_q  <= rx_data_d;
            rx_shift_q <= rx_shift_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = ~cs_q;

endmodule

// File: tb/tb_wb_spi_master.sv
// Randomized self-checking bench for wb_spi_master against a register-level reference model.
module tb_wb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [3:0]  wb_sel_i = 4'h0;
    logic [31:0] wb_adr_i = 32'h0;
    logic [31:0] wb_dat_i = 32'h0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    wb_spi_master dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Cycle stamp is advanced on the falling clk edge so it is stable at every rising edge.
    int unsigned cyc_cnt = 0;
    int unsigned rise_cnt = 0;
    int unsigned fall_cnt = 0;
    int unsigned fall_cyc = 0;
    logic [7:0]  mosi_cap = 8'h00;
    always @(negedge clk) cyc_cnt++;
    always @(posedge spi_sclk) begin
        rise_cnt++;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
    end
    always @(negedge spi_sclk) begin
        fall_cnt++;
        fall_cyc = cyc_cnt;
    end

    logic [7:0]  miso_pat = 8'h00;
    logic        loop_en = 1'b0;
    int unsigned rise_base = 0;
    always_comb begin
        int unsigned k;
        k = rise_cnt - rise_base;
        if (loop_en)     spi_miso = spi_mosi;
        else if (k < 8)  spi_miso = miso_pat[3'(7 - k)];
        else             spi_miso = 1'b0;
    end

    // Reference model of the register file.
    logic [15:0] div_m = 16'd3;
    logic        cs_m = 1'b0;
    logic        ovr_m = 1'b0;
    logic        rxv_m = 1'b0;
    logic [7:0]  rxd_m = 8'h00;
    logic        busy_m = 1'b0;
    int unsigned ack_cyc = 0;

    task automatic model_reset();
        div_m = 16'd3; cs_m = 1'b0; ovr_m = 1'b0; rxv_m = 1'b0; rxd_m = 8'h00; busy_m = 1'b0;
    endtask

    task automatic bus(input logic we, input logic [1:0] a, input logic [3:0] sel,
                       input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
        wb_adr_i = {28'h0, a, 2'b00}; wb_sel_i = sel; wb_dat_i = d;
        @(posedge clk); #1;
        check_val("ack_rise", 32'(wb_ack_o), 32'd1);
        rd = wb_dat_o;
        ack_cyc = cyc_cnt;
        @(negedge clk);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        check_val("ack_single", 32'(wb_ack_o), 32'd0);
        check_val("dat_idle", wb_dat_o, 32'h0);
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] unused;
        bus(1'b1, a, sel, d, unused);
        case (a)
            2'd1: if (sel[0] && d[2]) ovr_m = 1'b0;
            2'd2: begin
                if (sel[0]) div_m[7:0]  = d[7:0];
                if (sel[1]) div_m[15:8] = d[15:8];
            end
            2'd3: if (sel[0]) cs_m = d[0];
            default: ;
        endcase
    endtask

    task automatic rd_chk(input logic [1:0] a, input string tag);
        logic [31:0] got, exp;
        case (a)
            2'd0:    exp = {24'h0, rxd_m};
            2'd1:    exp = {29'h0, ovr_m, rxv_m, busy_m};
            2'd2:    exp = {16'h0, div_m};
            default: exp = {31'h0, cs_m};
        endcase
        bus(1'b0, a, 4'hF, 32'h0, got);
        check_val(tag, got, exp);
        if (a == 2'd0) rxv_m = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] tx, input logic [7:0] pat, input logic loop,
                        input logic ovr, input logic rd_at_end);
        logic [31:0] unused;
        int unsigned fb, start, len, budget;
        logic [7:0]  rx_exp;
        miso_pat  = pat;
        loop_en   = loop;
        rise_base = rise_cnt;
        fb        = fall_cnt;
        len       = 16 * (int'(div_m) + 1);
        budget    = len + 64;
        rx_exp    = loop ? tx : pat;
        bus(1'b1, 2'd0, 4'h1, {24'($urandom()), tx}, unused);
        start  = ack_cyc;
        busy_m = 1'b1;
        rd_chk(2'd1, "status_busy");
        if (ovr) begin
            bus(1'b1, 2'd0, 4'h1, {24'h0, ~tx}, unused);
            ovr_m = 1'b1;
            rd_chk(2'd1, "status_ovr");
        end
        if (rd_at_end) begin
            for (int i = 0; i < int'(budget) && cyc_cnt != start + len - 1; i++) begin
                @(posedge clk); #1;
            end
            check_val("sync_cycle", cyc_cnt, start + len - 1);
            rd_chk(2'd0, "data_old");
        end else begin
            for (int i = 0; i < int'(budget) && (fall_cnt - fb) < 8; i++) begin
                @(posedge clk); #1;
            end
        end
        check_val("sclk_falls", fall_cnt - fb, 32'd8);
        check_val("sclk_rises", rise_cnt - rise_base, 32'd8);
        check_val("xfer_len", fall_cyc - start, len);
        check_val("mosi_byte", {24'h0, mosi_cap}, {24'h0, tx});
        check_val("sclk_idle", 32'(spi_sclk), 32'd0);
        busy_m = 1'b0;
        rxv_m  = 1'b1;
        rxd_m  = rx_exp;
        rd_chk(2'd1, "status_done");
        rd_chk(2'd0, "data_rx");
        rd_chk(2'd1, "status_clr");
    endtask

    initial begin
        int unsigned fb;
        logic [31:0] unused;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_sclk", 32'(spi_sclk), 32'd0);
        check_val("rst_cs_n", 32'(spi_cs_n), 32'd1);
        check_val("rst_mosi", 32'(spi_mosi), 32'd0);
        check_val("rst_ack", 32'(wb_ack_o), 32'd0);
        @(negedge clk) rst = 1'b0;
        rd_chk(2'd1, "rst_status");
        rd_chk(2'd2, "rst_div");

        // Loopback A5 at DIV=1.
        reg_wr(2'd3, 4'h1, 32'h1);
        check_val("cs_low", 32'(spi_cs_n), 32'(!cs_m));
        reg_wr(2'd2, 4'h3, 32'h1);
        xfer(8'hA5, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fastest clock, MISO held high.
        reg_wr(2'd2, 4'h3, 32'h0);
        xfer(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Overrun while busy, then clear it.
        reg_wr(2'd2, 4'h3, 32'h2);
        xfer(8'h12, 8'h3C, 1'b0, 1'b1, 1'b0);
        rd_chk(2'd1, "status_ovr_kept");
        reg_wr(2'd1, 4'h1, 32'h4);
        rd_chk(2'd1, "status_ovr_clr");

        // Byte-lane DIV writes and full-scale value.
        reg_wr(2'd2, 4'h3, 32'h3);
        reg_wr(2'd2, 4'h1, 32'hFFFF_FF07);
        rd_chk(2'd2, "div_lane");
        reg_wr(2'd2, 4'h3, 32'hABCD_FFFF);
        rd_chk(2'd2, "div_max");
        reg_wr(2'd2, 4'h2, 32'h0000_00FF);
        rd_chk(2'd2, "div_lane_hi");

        // DATA read on the completion cycle.
        reg_wr(2'd2, 4'h3, 32'h1);
        xfer(8'h5A, 8'hC3, 1'b0, 1'b0, 1'b0);
        xfer(8'h96, 8'h69, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            logic [7:0] tx, pat;
            logic       lp, ov;
            reg_wr(2'd2, 4'($urandom()) | 4'h1, {16'($urandom()), 8'h00, 8'($urandom_range(0, 3))});
            rd_chk(2'd2, "rand_div");
            reg_wr(2'd3, 4'h1, 32'($urandom_range(0, 1)));
            check_val("rand_cs", 32'(spi_cs_n), 32'(!cs_m));
            tx  = 8'($urandom());
            pat = 8'($urandom());
            lp  = 1'($urandom());
            ov  = (div_m != 16'd0) && 1'($urandom());
            xfer(tx, pat, lp, ov, 1'b0);
            if (ov) reg_wr(2'd1, 4'h1, 32'h4);
        end

        // Asynchronous reset in the middle of a transfer.
        reg_wr(2'd3, 4'h1, 32'h1);
        reg_wr(2'd2, 4'h3, 32'h1);
        fb = fall_cnt;
        bus(1'b1, 2'd0, 4'h1, 32'h0000_00F0, unused);
        for (int i = 0; i < 200 && (fall_cnt - fb) < 4; i++) begin
            @(posedge clk); #1;
        end
        check_val("mid_falls", fall_cnt - fb, 32'd4);
        #2 rst = 1'b1;
        #1;
        check_val("arst_cs_n", 32'(spi_cs_n), 32'd1);
        check_val("arst_sclk", 32'(spi_sclk), 32'd0);
        check_val("arst_mosi", 32'(spi_mosi), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        rd_chk(2'd1, "post_rst_status");
        rd_chk(2'd2, "post_rst_div");
        rd_chk(2'd3, "post_rst_cs");
        xfer(8'hE7, 8'h81, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
